fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the address of the asynchronous-read instruction memory,
//  and captures the returned word into the IF/ID pipeline register for the decoder.
//  Sits directly upstream of instruction memory (drives its address) and downstream of it (registers its data).
//  Handles sequential fetch, stall and branch/jump redirect with wrong-path flush.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; first address presented to instruction memory
//  NOP_INSTR  32'h0000_0013  bubble word (addi x0,x0,0) written into IF/ID on reset/flush
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   hazard-unit hold request: freeze PC and IF/ID
//  pc_src         in   1   redirect request: branch taken / jump resolved this cycle
//  branch_target  in   32  redirect destination byte address, valid when pc_src=1
//  imem_addr      out  32  byte address to instruction memory (= current PC)
//  imem_rdata     in   32  instruction word returned combinationally for imem_addr
//  if_id_instr    out  32  registered instruction for decode
//  if_id_pc       out  32  registered PC of if_id_instr
//  if_id_pc4      out  32  registered PC+4 of if_id_instr
//  if_id_valid    out  1   1 = if_id_instr is a real fetched instruction; 0 = bubble
//  misalign_err   out  1   sticky misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  - imem_addr = pc, purely combinational; memory read is same-cycle, so capture latency is 1 cycle:
//    word at address A appears on if_id_instr the cycle after pc=A.
//  - Reset (rst=1 at edge): pc<=RESET_PC; if_id_instr<=NOP_INSTR; if_id_pc<=0; if_id_pc4<=0;
//    if_id_valid<=0; misalign_err<=0. rst overrides every other input.
//  - Priority per edge when rst=0: pc_src > stall > normal.
//  - Normal (pc_src=0, stall=0): pc<=pc+4; if_id_instr<=imem_rdata; if_id_pc<=pc; if_id_pc4<=pc+4; if_id_valid<=1.
//  - Stall (pc_src=0, stall=1): pc and all if_id_* hold their values; imem_addr stays constant.
//  - Redirect (pc_src=1, any stall): pc<=branch_target; if_id_instr<=NOP_INSTR; if_id_valid<=0;
//    if_id_pc/if_id_pc4 hold. The word fetched this cycle is wrong-path and is discarded.
//    Redirect wins over stall: the resolving stage is downstream and the IF word is never valid.
//  - Back-to-back redirects: each accepted; every cycle with pc_src=1 yields a bubble.
//  - Arithmetic: pc+4 is 32-bit modulo; pc=32'hFFFF_FFFC -> next pc 32'h0000_0000, if_id_pc4=0.
//  - First edge after reset release captures the word at RESET_PC with if_id_valid=1 (unless stalled/redirected).
//  - Reset mid-stall or mid-redirect: reset values apply at that edge; pending requests are dropped.
//  - No handshake with memory: imem_rdata must be valid in the same cycle imem_addr changes.
// CONFIGURATION
//  Macro FETCH_ALIGN_CHECK_EN:
//   defined: on redirect with branch_target[1:0]!=0, pc<=({branch_target[31:2],2'b00}) and
//            misalign_err<=1; stays 1 until rst. Aligned redirects do not change misalign_err.
//   undefined: branch_target loaded unmodified; misalign_err tied to 0; no extra logic.
// TESTING
//  1 Reset: rst=1 two edges, RESET_PC=0 -> imem_addr=0, if_id_valid=0, if_id_instr=32'h0000_0013.
//  2 Sequential: release rst, memory words 0x00500093,0x00100113,0x002081B3 at 0,4,8 -> if_id_instr
//    follows one cycle behind, if_id_pc=0,4,8, if_id_pc4=4,8,12, valid=1.
//  3 Stall: stall=1 for 3 cycles at pc=8 -> imem_addr=8 and if_id_* unchanged; release -> pc=12 next edge.
//  4 Redirect+stall: pc=12, pc_src=1, stall=1, branch_target=0x40 -> pc=0x40, if_id_valid=0,
//    if_id_instr=NOP; next edge captures word at 0x40 with if_id_pc=0x40.
//  5 Wrap: force pc=0xFFFF_FFFC via redirect -> next pc=0, if_id_pc=0xFFFF_FFFC, if_id_pc4=0.
//  6 FETCH_ALIGN_CHECK_EN defined: branch_target=0x46 -> pc=0x44, misalign_err=1, held after
//    aligned redirect; cleared only by rst. Undefined: pc=0x46, misalign_err=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and the IF/ID register.
// Define FETCH_ALIGN_CHECK_EN to word-align redirect targets and flag misaligned redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err
);

  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;
  logic [31:0] pc_inc;
  logic [31:0] redirect_pc;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign pc_inc    = next_seq_pc(pc_p0);
  assign imem_addr = pc_p0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_p0;

  assign redirect_pc  = word_align(branch_target);
  assign misalign_err = misalign_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_p0 <= 1'b0;
    end else if (pc_src && (branch_target[1:0] != 2'b00)) begin
      misalign_p0 <= 1'b1;
    end
  end
`else
  assign redirect_pc  = branch_target;
  assign misalign_err = 1'b0;
`endif

  // p0 -> p1: PC update and IF/ID capture; redirect beats stall, stall beats sequential fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= 32'd0;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (pc_src) begin
      pc_p0    <= redirect_pc;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (!stall) begin
      pc_p0    <= pc_inc;
      instr_p1 <= imem_rdata;
      pc_p1    <= pc_p0;
      pc4_p1   <= pc_inc;
      vld_p1   <= 1'b1;
    end
  end

  assign if_id_instr = instr_p1;
  assign if_id_pc    = pc_p1;
  assign if_id_pc4   = pc4_p1;
  assign if_id_valid = vld_p1;

endmodule
